letc_core_mem_arbiter: RTL and testbench
========================================

LETC_CORE_MEM_ARBITER -- requirements
Module: letc_core_mem_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3, is the number of requester ports; index 0 is L1I, 1 is L1D, 2 is MMU.
REQ-002 One clock, i_clk; reset is asynchronous and active-high, named i_rst.
REQ-003 Ports:
- i_clk  in  1  core clock
- i_rst  in  1  async active-high reset
- i_req_valid  in  [NUM_REQ]  request pending
- o_req_ready  out  [NUM_REQ]  one-hot completion pulse
- i_req_wen_nren  in  [NUM_REQ]  1=write, 0=read
- i_req_size  in  size_e[NUM_REQ]  access size
- i_req_addr  in  paddr_t[NUM_REQ]  physical address
- i_req_wdata  in  word_t[NUM_REQ]  write data
- o_req_rdata  out  word_t  read data, broadcast to all requesters
- o_mem_valid  out  1  downstream request valid
- i_mem_ready  in  1  downstream completion pulse; i_mem_rdata valid this cycle
- o_mem_wen_nren  out  1  granted request's direction
- o_mem_size  out  size_e  granted request's size
- o_mem_addr  out  paddr_t  granted request's address
- o_mem_wdata  out  word_t  granted request's write data
- i_mem_rdata  in  word_t  downstream read data

Function
REQ-004 Handshake: a requester holds valid and all request fields stable from assertion until the cycle its o_req_ready is 1; a transfer completes in the cycle valid & ready.
REQ-005 FSM states: IDLE and BUSY.
- IDLE -> BUSY when any i_req_valid is 1.
- BUSY -> IDLE when i_mem_ready is 1 and no eligible requester is pending.
- BUSY -> BUSY when i_mem_ready is 1 and an eligible requester is pending; this is a back-to-back grant.
REQ-006 Arbitration is round-robin. Pointer ptr is $clog2(NUM_REQ) bits. The winner is the first valid index at or after ptr, searching upward modulo NUM_REQ.
REQ-007 At grant, the winner index and its wen_nren, size, addr and wdata are registered. o_mem_* are driven only from these registers, so the downstream port sees the request one cycle after the grant decision.
REQ-008 o_mem_valid is 1 exactly when state is BUSY.
REQ-009 In BUSY with i_mem_ready=1:
- o_req_ready[grant] is 1 combinationally; all other o_req_ready bits are 0.
- o_req_rdata equals i_mem_rdata.
- ptr becomes grant+1, wrapping from NUM_REQ-1 to 0.
REQ-010 For a same-cycle re-grant, the completing requester is ineligible. The winner is chosen from the remaining valid bits using the updated ptr.
REQ-011 o_req_ready is all-zero in IDLE and whenever i_mem_ready is 0. i_mem_ready in IDLE is ignored.
REQ-012 o_req_rdata equals i_mem_rdata in all cycles; requesters qualify it with their own o_req_ready.
REQ-013 Fairness: any continuously valid requester completes within NUM_REQ grants.
REQ-014 Registered request fields do not change while BUSY, even if requester inputs change, which is illegal.

Reset
REQ-015 While i_rst=1, and asynchronously on its assertion:
- state = IDLE, ptr = 0, grant = 0;
- o_mem_valid = 0, o_req_ready = 0;
- registered wen_nren, size, addr and wdata = 0.
REQ-016 Reset asserted mid-transaction abandons it with no o_req_ready pulse; the downstream AXI FSM shares this reset.
REQ-017 The first arbitration after reset deasserts starts at ptr = 0.

Structure
REQ-018 size_e, paddr_t and word_t come from letc_pkg. The arbiter state enum and NUM_MEM_REQ = 3 belong in letc_core_pkg.
REQ-019 One sub-module, letc_core_rr_pick: a combinational parameterized round-robin picker with inputs (request mask, ptr) and outputs (any, index).
REQ-020 letc_core_top instantiates the arbiter between the cache/MMU request ports and a single-port letc_core_axi_fsm.

Verification
REQ-021 Single read: valid=3'b001, addr=0x8000_0000, read; mem_ready 2 cycles after o_mem_valid with rdata=0xDEADBEEF -> o_mem_valid high 2 cycles, o_req_ready=3'b001 in the completion cycle, o_req_rdata=0xDEADBEEF, FSM back to IDLE.
REQ-022 Contention: all three valid from reset, mem_ready=1 on every cycle of o_mem_valid -> grant order 0,1,2, back-to-back with no IDLE cycle, final ptr=0.
REQ-023 Exclusion: req0 and req1 valid, req0 re-asserts valid immediately after its completion -> req1 granted next, and req0 is not granted twice in a row.
REQ-024 Write passthrough: req2 write, addr=0x0000_1004, size=word, wdata=0x1234_5678 -> o_mem_* match these values exactly while BUSY; requester inputs changed mid-BUSY do not alter o_mem_*.
REQ-025 Reset mid-op: i_rst asserted in BUSY before mem_ready -> o_mem_valid=0 and o_req_ready=0 immediately; after release with req1 valid, req1 is granted (ptr=0 search).
REQ-026 Assertions:
- o_req_ready is onehot0;
- o_req_ready[i] implies i_req_valid[i];
- the starvation bound of REQ-013 holds.

Source files
------------

// File: rtl/letc_core_pkg.sv
// Core-level constants and the memory arbiter state encoding.
package letc_core_pkg;

    localparam int NUM_MEM_REQ = 3;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/letc_pkg.sv
// Shared LETC data types: physical address, data word and access size.
package letc_pkg;

    typedef logic [31:0] word_t;
    typedef logic [33:0] paddr_t;

    typedef enum logic [1:0] {
        SIZE_BYTE     = 2'b00,
        SIZE_HALFWORD = 2'b01,
        SIZE_WORD     = 2'b10
    } size_e;

endpackage

// File: rtl/letc_core_rr_pick.sv
// Combinational round-robin picker: first set mask bit at or after ptr, wrapping modulo N.
module letc_core_rr_pick #(
    parameter  int N = 3,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] mask,
    input  logic [W-1:0] ptr,
    output logic         any,
    output logic [W-1:0] index
);

    logic found;
    int unsigned cand;

    always_comb begin
        any   = |mask;
        index = '0;
        found = 1'b0;
        cand  = 0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = int'(ptr) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!found && mask[cand]) begin
                index = W'(cand);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/letc_core_mem_arbiter.sv
// Round-robin arbiter funnelling L1I/L1D/MMU requests onto one memory port.
module letc_core_mem_arbiter
    import letc_pkg::*;
    import letc_core_pkg::*;
#(
    parameter int NUM_REQ = NUM_MEM_REQ
) (
    input  logic               i_clk,
    input  logic               i_rst,

    input  logic [NUM_REQ-1:0] i_req_valid,
    output logic [NUM_REQ-1:0] o_req_ready,
    input  logic [NUM_REQ-1:0] i_req_wen_nren,
    input  size_e              i_req_size  [NUM_REQ],
    input  paddr_t             i_req_addr  [NUM_REQ],
    input  word_t              i_req_wdata [NUM_REQ],
    output word_t              o_req_rdata,

    output logic               o_mem_valid,
    input  logic               i_mem_ready,
    output logic               o_mem_wen_nren,
    output size_e              o_mem_size,
    output paddr_t             o_mem_addr,
    output word_t              o_mem_wdata,
    input  word_t              i_mem_rdata
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_e state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] grant_q;
    logic [PW-1:0] grant_inc;
    logic [PW-1:0] ptr_eff;
    logic [PW-1:0] pick_idx;
    logic          pick_any;
    logic          done;
    logic          load;
    logic [NUM_REQ-1:0] eligible;

    logic   wen_q;
    size_e  size_q;
    paddr_t addr_q;
    word_t  wdata_q;

    assign done      = (state_q == ARB_BUSY) && i_mem_ready;
    assign grant_inc = (grant_q == PW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

    // On completion the finishing requester is masked out and the search
    // already uses the advanced pointer, so a re-grant never repeats it.
    always_comb begin
        eligible = i_req_valid;
        if (done) begin
            eligible[grant_q] = 1'b0;
        end
        ptr_eff = done ? grant_inc : ptr_q;
    end

    letc_core_rr_pick #(
        .N(NUM_REQ)
    ) u_pick (
        .mask  (eligible),
        .ptr   (ptr_eff),
        .any   (pick_any),
        .index (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        load    = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    state_d = ARB_BUSY;
                    load    = 1'b1;
                end
            end
            ARB_BUSY: begin
                if (done) begin
                    ptr_d = grant_inc;
                    if (pick_any) begin
                        load = 1'b1;
                    end else begin
                        state_d = ARB_IDLE;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        o_req_ready = '0;
        if (done) begin
            o_req_ready[grant_q] = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ARB_IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            wen_q   <= 1'b0;
            size_q  <= size_e'(2'b00);
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            if (load) begin
                grant_q <= pick_idx;
                wen_q   <= i_req_wen_nren[pick_idx];
                size_q  <= i_req_size[pick_idx];
                addr_q  <= i_req_addr[pick_idx];
                wdata_q <= i_req_wdata[pick_idx];
            end
        end
    end

    assign o_mem_valid    = (state_q == ARB_BUSY);
    assign o_mem_wen_nren = wen_q;
    assign o_mem_size     = size_q;
    assign o_mem_addr     = addr_q;
    assign o_mem_wdata    = wdata_q;
    assign o_req_rdata    = i_mem_rdata;

endmodule

// File: tb/tb_letc_core_mem_arbiter.sv
// Directed-vector bench for letc_core_mem_arbiter with per-cycle protocol invariants.
module tb_letc_core_mem_arbiter;
    import letc_pkg::*;

    localparam int NR = 3;
    localparam paddr_t A0 = 34'h0_8000_0000;
    localparam paddr_t A1 = 34'h0_8000_0100;
    localparam paddr_t A2 = 34'h0_0000_1004;

    logic          clk;
    logic          rst;
    logic [NR-1:0] req_valid;
    logic [NR-1:0] req_ready;
    logic [NR-1:0] req_wen;
    size_e         req_size  [NR];
    paddr_t        req_addr  [NR];
    word_t         req_wdata [NR];
    word_t         req_rdata;
    logic          mem_valid;
    logic          mem_ready;
    logic          mem_wen;
    size_e         mem_size;
    paddr_t        mem_addr;
    word_t         mem_wdata;
    word_t         mem_rdata;

    int n_vec;
    int n_fail;
    int wait_cnt [NR];

    letc_core_mem_arbiter #(
        .NUM_REQ(NR)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_req_valid    (req_valid),
        .o_req_ready    (req_ready),
        .i_req_wen_nren (req_wen),
        .i_req_size     (req_size),
        .i_req_addr     (req_addr),
        .i_req_wdata    (req_wdata),
        .o_req_rdata    (req_rdata),
        .o_mem_valid    (mem_valid),
        .i_mem_ready    (mem_ready),
        .o_mem_wen_nren (mem_wen),
        .o_mem_size     (mem_size),
        .o_mem_addr     (mem_addr),
        .o_mem_wdata    (mem_wdata),
        .i_mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic          rst;
        logic [NR-1:0] valid;
        logic          mem_ready;
        word_t         rdata;
        logic [NR-1:0] exp_ready;
        logic          exp_mv;
        paddr_t        exp_addr;
    } vec_t;

    vec_t tbl [21];

    function automatic vec_t mk(logic r, logic [NR-1:0] v, logic mr, word_t rd,
                                logic [NR-1:0] er, logic emv, paddr_t ea);
        vec_t t;
        t.rst = r; t.valid = v; t.mem_ready = mr; t.rdata = rd;
        t.exp_ready = er; t.exp_mv = emv; t.exp_addr = ea;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Protocol properties that must hold on every sampled cycle.
    task automatic check_inv();
        int worst;
        worst = 0;
        chk("onehot0", 64'($onehot0(req_ready)), 64'd1);
        chk("ready_implies_valid", 64'(req_ready & ~req_valid), 64'd0);
        chk("rdata_passthrough", 64'(req_rdata), 64'(mem_rdata));
        for (int i = 0; i < NR; i++) begin
            if (!req_valid[i] || req_ready[i]) begin
                wait_cnt[i] = 0;
            end else if (|req_ready) begin
                wait_cnt[i]++;
            end
            if (wait_cnt[i] > worst) worst = wait_cnt[i];
        end
        chk("starvation_bound", 64'(worst >= NR), 64'd0);
    endtask

    task automatic drive(input logic r, input logic [NR-1:0] v, input logic mr, input word_t rd);
        rst       = r;
        req_valid = v;
        mem_ready = mr;
        mem_rdata = rd;
    endtask

    task automatic expect_cyc(input string name, input logic [NR-1:0] er,
                              input logic emv, input paddr_t ea);
        @(negedge clk);
        chk({name, ".ready"}, 64'(req_ready), 64'(er));
        chk({name, ".mem_valid"}, 64'(mem_valid), 64'(emv));
        chk({name, ".mem_addr"}, 64'(mem_addr), 64'(ea));
        check_inv();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec  = 0;
        n_fail = 0;
        for (int i = 0; i < NR; i++) wait_cnt[i] = 0;
        req_wen      = '0;
        req_size[0]  = SIZE_WORD;  req_size[1]  = SIZE_WORD;  req_size[2]  = SIZE_WORD;
        req_addr[0]  = A0;         req_addr[1]  = A1;         req_addr[2]  = A2;
        req_wdata[0] = 32'h1;      req_wdata[1] = 32'h2;      req_wdata[2] = 32'h3;
        drive(1'b1, '0, 1'b0, '0);

        // single read, then contention from reset, ptr-after-wrap probe, exclusion
        tbl[0]  = mk(1, 3'b000, 0, 32'hC0DE_0000, 3'b000, 0, '0);
        tbl[1]  = mk(0, 3'b001, 0, 32'hC0DE_0001, 3'b000, 0, '0);
        tbl[2]  = mk(0, 3'b001, 0, 32'hC0DE_0002, 3'b000, 1, A0);
        tbl[3]  = mk(0, 3'b001, 1, 32'hDEAD_BEEF, 3'b001, 1, A0);
        tbl[4]  = mk(0, 3'b000, 0, 32'hC0DE_0004, 3'b000, 0, A0);
        tbl[5]  = mk(1, 3'b000, 0, 32'hC0DE_0005, 3'b000, 0, '0);
        tbl[6]  = mk(0, 3'b111, 0, 32'hC0DE_0006, 3'b000, 0, '0);
        tbl[7]  = mk(0, 3'b111, 1, 32'hC0DE_0007, 3'b001, 1, A0);
        tbl[8]  = mk(0, 3'b110, 1, 32'hC0DE_0008, 3'b010, 1, A1);
        tbl[9]  = mk(0, 3'b100, 1, 32'hC0DE_0009, 3'b100, 1, A2);
        tbl[10] = mk(0, 3'b000, 1, 32'hC0DE_000A, 3'b000, 0, A2);
        tbl[11] = mk(0, 3'b101, 0, 32'hC0DE_000B, 3'b000, 0, A2);
        tbl[12] = mk(0, 3'b101, 0, 32'hC0DE_000C, 3'b000, 1, A0);
        tbl[13] = mk(0, 3'b101, 1, 32'hC0DE_000D, 3'b001, 1, A0);
        tbl[14] = mk(0, 3'b100, 1, 32'hC0DE_000E, 3'b100, 1, A2);
        tbl[15] = mk(0, 3'b000, 0, 32'hC0DE_000F, 3'b000, 0, A2);
        tbl[16] = mk(0, 3'b011, 0, 32'hC0DE_0010, 3'b000, 0, A2);
        tbl[17] = mk(0, 3'b011, 1, 32'hC0DE_0011, 3'b001, 1, A0);
        tbl[18] = mk(0, 3'b011, 1, 32'hC0DE_0012, 3'b010, 1, A1);
        tbl[19] = mk(0, 3'b001, 1, 32'hC0DE_0013, 3'b001, 1, A0);
        tbl[20] = mk(0, 3'b000, 0, 32'hC0DE_0014, 3'b000, 0, A0);

        for (int i = 0; i < 21; i++) begin
            drive(tbl[i].rst, tbl[i].valid, tbl[i].mem_ready, tbl[i].rdata);
            expect_cyc($sformatf("v%0d", i), tbl[i].exp_ready, tbl[i].exp_mv, tbl[i].exp_addr);
        end

        // Write passthrough; request fields must stay latched while BUSY
        req_wen[2]   = 1'b1;
        req_size[2]  = SIZE_WORD;
        req_addr[2]  = 34'h0_0000_1004;
        req_wdata[2] = 32'h1234_5678;
        drive(0, 3'b100, 0, 32'h0);
        expect_cyc("wr.idle", 3'b000, 0, A0);
        drive(0, 3'b100, 0, 32'h0);
        @(negedge clk);
        chk("wr.mem_valid", 64'(mem_valid), 64'd1);
        chk("wr.wen", 64'(mem_wen), 64'd1);
        chk("wr.size", 64'(mem_size), 64'(SIZE_WORD));
        chk("wr.addr", 64'(mem_addr), 64'h1004);
        chk("wr.wdata", 64'(mem_wdata), 64'h1234_5678);
        check_inv();
        @(posedge clk); #1;
        req_wen[2]   = 1'b0;
        req_size[2]  = SIZE_BYTE;
        req_addr[2]  = 34'h0_0000_2000;
        req_wdata[2] = 32'h0;
        @(negedge clk);
        chk("wr.hold.wen", 64'(mem_wen), 64'd1);
        chk("wr.hold.size", 64'(mem_size), 64'(SIZE_WORD));
        chk("wr.hold.addr", 64'(mem_addr), 64'h1004);
        chk("wr.hold.wdata", 64'(mem_wdata), 64'h1234_5678);
        check_inv();
        @(posedge clk); #1;
        req_wen[2]   = 1'b1;
        req_size[2]  = SIZE_WORD;
        req_addr[2]  = A2;
        req_wdata[2] = 32'h1234_5678;
        drive(0, 3'b100, 1, 32'h0BAD_F00D);
        expect_cyc("wr.done", 3'b100, 1, A2);
        req_wen[2]   = 1'b0;
        req_wdata[2] = 32'h3;
        drive(0, 3'b000, 0, 32'h0);
        expect_cyc("wr.after", 3'b000, 0, A2);

        // Asynchronous reset in BUSY, coinciding with mem_ready, drops everything at once
        drive(0, 3'b001, 0, 32'h0);
        expect_cyc("rst.idle", 3'b000, 0, A2);
        drive(0, 3'b001, 0, 32'h0);
        @(negedge clk);
        chk("rst.busy", 64'(mem_valid), 64'd1);
        #2;
        rst       = 1'b1;
        mem_ready = 1'b1;
        mem_rdata = 32'h5555_AAAA;
        #1;
        chk("rst.async.mem_valid", 64'(mem_valid), 64'd0);
        chk("rst.async.ready", 64'(req_ready), 64'd0);
        chk("rst.async.addr", 64'(mem_addr), 64'd0);
        chk("rst.async.wdata", 64'(mem_wdata), 64'd0);
        chk("rst.async.size", 64'(mem_size), 64'd0);
        check_inv();
        @(posedge clk); #1;
        drive(0, 3'b010, 0, 32'h0);
        expect_cyc("rst.rel", 3'b000, 0, '0);
        drive(0, 3'b010, 1, 32'h7777_1111);
        expect_cyc("rst.req1", 3'b010, 1, A1);
        drive(0, 3'b000, 0, 32'h0);
        expect_cyc("rst.end", 3'b000, 0, A1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
